// File: rtl/fetch_pc_stage_pkg.sv
// Shared core definitions for the fetch front end: widths, the flush NOP,
// the fetch FSM states and the IF/ID pipeline-register layout used by decode.
package fetch_pc_stage_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select: sequential pc+4 (wrapping) or the word-aligned redirect target.
module next_pc_mux
  import fetch_pc_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] next_pc_o
);

  // Align the target and pick between it and the sequential address
  always_comb begin
    target_o = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
    if (redirect_i) begin
      next_pc_o = target_o;
    end else begin
      next_pc_o = pc_i + {{(XLEN-3){1'b0}}, 3'd4};
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, imem request handshake and IF/ID register,
// with stall, flush and redirect-while-outstanding (KILL) handling.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [31:0]     ifid_instr_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] saved_pc_q, saved_pc_d;
  logic [31:0]     rsp_buf_q, rsp_buf_d;
  ifid_t           ifid_q, ifid_d;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] next_pc_s;

  next_pc_mux u_next_pc_mux (
    .pc_i          (pc_q),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .target_o      (target_s),
    .next_pc_o     (next_pc_s)
  );

  // Next-state, next-PC and IF/ID update for the fetch FSM
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    rsp_buf_d  = rsp_buf_q;
    ifid_d     = ifid_q;
    imem_req_o = 1'b0;

    case (state_q)
      IDLE: begin
        imem_req_o = !stall_i && !redirect_i;
        if (redirect_i) begin
          pc_d         = next_pc_s;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (stall_i) begin
          state_d = IDLE;
        end else if (imem_ready_i) begin
          ifid_d  = '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i};
          pc_d    = next_pc_s;
        end else begin
          ifid_d.valid = 1'b0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          saved_pc_d   = target_s;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
          // A response landing with the redirect is dropped; no need to wait in KILL
          if (imem_ready_i) begin
            pc_d    = target_s;
            state_d = IDLE;
          end else begin
            state_d = KILL;
          end
        end else if (imem_ready_i && !stall_i) begin
          ifid_d  = '{valid: 1'b1, pc: pc_q, instr: imem_rdata_i};
          pc_d    = next_pc_s;
          state_d = IDLE;
        end else if (imem_ready_i) begin
          rsp_buf_d = imem_rdata_i;
          state_d   = HOLD;
        end else if (!stall_i) begin
          ifid_d.valid = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      KILL: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          saved_pc_d = target_s;
        end else begin
          saved_pc_d = saved_pc_q;
        end
        if (imem_ready_i) begin
          pc_d    = redirect_i ? target_s : saved_pc_q;
          state_d = IDLE;
        end else begin
          state_d = KILL;
        end
      end
      HOLD: begin
        imem_req_o = 1'b0;
        if (redirect_i) begin
          pc_d         = target_s;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
          state_d      = IDLE;
        end else if (!stall_i) begin
          ifid_d  = '{valid: 1'b1, pc: pc_q, instr: rsp_buf_q};
          pc_d    = next_pc_s;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      saved_pc_q   <= {XLEN{1'b0}};
      rsp_buf_q    <= 32'h0000_0000;
      ifid_q.valid <= 1'b0;
      ifid_q.pc    <= {XLEN{1'b0}};
      ifid_q.instr <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      rsp_buf_q  <= rsp_buf_d;
      ifid_q     <= ifid_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_valid_o = ifid_q.valid;
  assign ifid_pc_o    = ifid_q.pc;
  assign ifid_instr_o = ifid_q.instr;

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
Instruction-fetch front end of the pipelined RISC-V core. Holds the program counter and selects the next PC with a 2:1 mux: sequential (pc+4) or redirect target. Handshakes with instruction memory and drives the IF/ID pipeline register consumed by decode. Supports a stall input and a redirect/flush input, including a redirect that arrives while a memory request is still outstanding.

Parameters:
XLEN, 32, address/data width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset or flush (addi x0,x0,0).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
stall_i  in  1  decode cannot accept; hold IF/ID and PC.
redirect_i  in  1  branch/jump taken; flush and refetch.
redirect_pc_i  in  XLEN  redirect target.
imem_req_o  out  1  fetch request.
imem_addr_o  out  XLEN  fetch address (always equals pc).
imem_ready_i  in  1  imem_rdata_i valid this cycle; completes the request.
imem_rdata_i  in  32  fetched instruction.
ifid_valid_o  out  1  IF/ID holds a real instruction.
ifid_pc_o  out  XLEN  PC of the IF/ID instruction.
ifid_instr_o  out  32  IF/ID instruction.

Behaviour:
- Reset (any state, mid-request included): pc=RESET_PC, state=IDLE, ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, buf=0, saved_pc=0.
- Memory contract: a request asserted without ready keeps imem_req_o=1 and imem_addr_o stable until ready. Ready with req=0 is ignored.
- imem_addr_o = pc in all states.
- Redirect target: bits [1:0] forced to 0 before use.
- pc+4 wraps modulo 2^XLEN (FFFF_FFFC -> 0).
- Flush writes ifid_valid_o=0 and ifid_instr_o=NOP_INSTR, and leaves ifid_pc_o unchanged. Flush ignores stall_i.
- IDLE:
  - imem_req_o = !stall_i && !redirect_i.
  - redirect_i: pc<=target, flush.
  - Else if stall_i: hold everything.
  - Else if ready: IF/ID<={pc, rdata, 1}, pc<=pc+4, stay IDLE. Zero-bubble throughput is 1 instr/cycle.
  - Else: ifid_valid_o<=0 (bubble), go to BUSY.
- BUSY:
  - imem_req_o = 1.
  - redirect_i: saved_pc<=target, flush, go to KILL. If ready is also high this cycle, the response is discarded and pc<=target, go to IDLE.
  - Else if ready and !stall_i: IF/ID<={pc, rdata, 1}, pc<=pc+4, go to IDLE.
  - Else if ready and stall_i: buf<=rdata, go to HOLD. IF/ID is held.
  - Else (not ready): if !stall_i, ifid_valid_o<=0; otherwise hold.
- KILL:
  - imem_req_o = 1, addr = old pc. IF/ID stays flushed.
  - Another redirect_i updates saved_pc (latest wins).
  - On ready: response discarded, pc<=saved_pc (or the same-cycle redirect target), go to IDLE.
- HOLD:
  - imem_req_o = 0.
  - redirect_i: pc<=target, flush, go to IDLE (buf dropped).
  - Else if !stall_i: IF/ID<={pc, buf, 1}, pc<=pc+4, go to IDLE.
  - Else: hold.
- Priority: rst > redirect_i > stall_i > imem_ready_i.

Decomposition:
- Shared core package holds:
  - XLEN;
  - NOP_INSTR;
  - fetch state enum {IDLE, BUSY, KILL, HOLD};
  - IF/ID struct {valid, pc, instr}, reused by decode.
- One sub-module, next_pc_mux: combinational 2:1 select of pc+4 vs aligned redirect target. Everything else, including the FSM and registers, stays in fetch_pc_stage.

Test Plan:
- Reset then ready tied 1, no stall -> imem_addr 0,4,8,… one per cycle; ifid_pc_o lags imem_addr_o by 1 cycle with matching rdata; ifid_valid_o=1 from the first cycle after reset is released.
- Ready low 3 cycles at pc=0x10 -> imem_req_o held, addr held at 0x10, ifid_valid_o=0 for those cycles; ready high -> ifid={0x10, rdata, 1}, next addr 0x14.
- Stall asserted while BUSY and ready arrives with rdata=0xDEADBEEF -> HOLD, IF/ID unchanged, req=0; stall released -> ifid_instr_o=0xDEADBEEF, ifid_valid_o=1.
- Redirect to 0x103 during BUSY at pc=0x20, ready after 2 cycles -> IF/ID flushed (NOP, valid 0), 0x20 response discarded, next addr 0x100.
- Redirect to 0x40 with stall high in IDLE -> flush applied despite stall, next addr 0x40; pc=0xFFFFFFFC fetched -> next addr 0x0.
- rst asserted while in KILL -> next cycle pc=RESET_PC, IDLE, ifid_valid_o=0, ifid_instr_o=NOP_INSTR.
